// File: rtl/uart_frame_assembler.sv
// Packs a UART byte stream into FRAME_BYTES-wide frames with an optional sync header.
// A partial frame is discarded after an inter-byte timeout, and a complete frame is held for a valid/ready handshake.
module uart_frame_assembler #(
    parameter int                BYTE_W         = 8,
    parameter int                FRAME_BYTES    = 16,
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter int                SYNC_EN        = 0,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = 8'hA5,
    parameter int                CNT_W          = 16,
    localparam int               IDX_W          = $clog2(FRAME_BYTES + 32'sd1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byte_valid,
    input  logic [BYTE_W-1:0]             byte_data,
    output logic [FRAME_BYTES*BYTE_W-1:0] frame_data,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [IDX_W-1:0]              byte_index,
    output logic                          timeout_err,
    output logic [CNT_W-1:0]              drop_count
);

    localparam int                IDLE_W     = (TIMEOUT_CYCLES > 32'sd1) ? $clog2(TIMEOUT_CYCLES) : 32'sd1;
    localparam bit                TIMEOUT_ON = (TIMEOUT_CYCLES > 32'sd0);
    localparam logic [IDX_W-1:0]  IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME_BYTES - 32'sd1);
    localparam logic [IDLE_W-1:0] IDLE_ZERO  = {IDLE_W{1'b0}};
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_ON ? (TIMEOUT_CYCLES - 32'sd1) : 32'sd0);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam state_t ST_START = (SYNC_EN != 32'sd0) ? ST_HUNT : ST_COLLECT;

    state_t                          state_q,       state_d;
    logic   [IDX_W-1:0]              byte_index_q,  byte_index_d;
    logic   [FRAME_BYTES*BYTE_W-1:0] frame_data_q,  frame_data_d;
    logic                            frame_valid_q, frame_valid_d;
    logic                            timeout_err_q, timeout_err_d;
    logic   [CNT_W-1:0]              drop_count_q,  drop_count_d;
    logic   [IDLE_W-1:0]             idle_q,        idle_d;
    logic                            hunt_byte_s;
    logic                            store_byte_s;
    logic                            timeout_hit_s;

    // The idle counter hits its last value on the TIMEOUT_CYCLES-th idle cycle after a byte.
    assign timeout_hit_s = TIMEOUT_ON && (byte_index_q != IDX_ZERO) && (idle_q == IDLE_LAST);

    // Next-state, frame storage, idle timeout and drop counting.
    always_comb begin
        state_d       = state_q;
        byte_index_d  = byte_index_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        drop_count_d  = drop_count_q;
        idle_d        = idle_q;
        timeout_err_d = 1'b0;
        hunt_byte_s   = 1'b0;
        store_byte_s  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                hunt_byte_s = byte_valid;
            end
            ST_COLLECT: begin
                if (byte_valid) begin
                    store_byte_s = 1'b1;
                end else if (timeout_hit_s) begin
                    byte_index_d  = IDX_ZERO;
                    idle_d        = IDLE_ZERO;
                    timeout_err_d = 1'b1;
                    state_d       = ST_START;
                end else if (byte_index_q != IDX_ZERO) begin
                    idle_d = idle_q + 1'b1;
                end else begin
                    idle_d = IDLE_ZERO;
                end
            end
            ST_HOLD: begin
                // A byte arriving with the handshake belongs to what follows the held frame.
                if (frame_ready) begin
                    frame_valid_d = 1'b0;
                    state_d       = ST_START;
                    hunt_byte_s   = byte_valid && (SYNC_EN != 32'sd0);
                    store_byte_s  = byte_valid && (SYNC_EN == 32'sd0);
                end else if (byte_valid && (drop_count_q != CNT_MAX)) begin
                    drop_count_d = drop_count_q + 1'b1;
                end else begin
                    drop_count_d = drop_count_q;
                end
            end
            default: begin
                state_d       = ST_START;
                byte_index_d  = IDX_ZERO;
                frame_valid_d = 1'b0;
            end
        endcase

        if (hunt_byte_s && (byte_data == SYNC_BYTE)) begin
            state_d      = ST_COLLECT;
            byte_index_d = IDX_ZERO;
            idle_d       = IDLE_ZERO;
        end else if (store_byte_s) begin
            frame_data_d[byte_index_q*BYTE_W +: BYTE_W] = byte_data;
            idle_d = IDLE_ZERO;
            if (byte_index_q == LAST_IDX) begin
                byte_index_d  = IDX_ZERO;
                frame_valid_d = 1'b1;
                state_d       = ST_HOLD;
            end else begin
                byte_index_d  = byte_index_q + 1'b1;
                state_d       = ST_COLLECT;
            end
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers; rst clears everything on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_START;
            byte_index_q  <= IDX_ZERO;
            frame_data_q  <= {(FRAME_BYTES*BYTE_W){1'b0}};
            frame_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
            drop_count_q  <= {CNT_W{1'b0}};
            idle_q        <= IDLE_ZERO;
        end else begin
            state_q       <= state_d;
            byte_index_q  <= byte_index_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            timeout_err_q <= timeout_err_d;
            drop_count_q  <= drop_count_d;
            idle_q        <= idle_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign byte_index  = byte_index_q;
    assign timeout_err = timeout_err_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench: two assemblers (no sync / sync with 2-bit drop counter) share one byte stream
// and are compared every cycle against a queue-based reference model.
module tb_uart_frame_assembler;

    localparam int TMO = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         byte_valid = 1'b0;
    logic [7:0]   byte_data = 8'h00;
    logic         rdy0 = 1'b0;
    logic         rdy1 = 1'b0;
    logic [127:0] fd0, fd1;
    logic         fv0, fv1, to0, to1;
    logic [4:0]   bi0, bi1;
    logic [15:0]  dc0;
    logic [1:0]   dc1;

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;

    // reference model state, per instance
    logic         m_hunt[2], m_hold[2], m_to[2];
    int           m_cnt[2], m_idle[2], m_drop[2];
    logic [127:0] m_fd[2];
    // model state as seen during the current cycle
    logic         s_hold[2], s_to[2];
    int           s_cnt[2], s_drop[2];
    logic [127:0] s_fd[2];
    logic [127:0] exp_q0[$];
    logic [127:0] exp_q1[$];

    always #5 clk = ~clk;

    uart_frame_assembler #(
        .BYTE_W(8), .FRAME_BYTES(16), .TIMEOUT_CYCLES(TMO), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .frame_data(fd0), .frame_valid(fv0), .frame_ready(rdy0),
        .byte_index(bi0), .timeout_err(to0), .drop_count(dc0)
    );

    uart_frame_assembler #(
        .BYTE_W(8), .FRAME_BYTES(16), .TIMEOUT_CYCLES(TMO), .SYNC_EN(1), .SYNC_BYTE(8'hA5), .CNT_W(2)
    ) u_dut_sync (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .frame_data(fd1), .frame_valid(fv1), .frame_ready(rdy1),
        .byte_index(bi1), .timeout_err(to1), .drop_count(dc1)
    );

    task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d: got %h want %h", nm, i, act, exp);
        end
    endtask

    function automatic int drop_max(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    // One clock of the reference model for instance i, given this cycle's inputs.
    task automatic model_cycle(input int i, input logic v, input logic [7:0] d, input logic rdy, input logic rs);
        logic acc;
        s_hold[i] = m_hold[i];
        s_cnt[i]  = m_cnt[i];
        s_drop[i] = m_drop[i];
        s_fd[i]   = m_fd[i];
        s_to[i]   = m_to[i];
        m_to[i]   = 1'b0;
        if (rs) begin
            m_hunt[i] = (i == 1);
            m_hold[i] = 1'b0;
            m_cnt[i]  = 0;
            m_idle[i] = 0;
            m_drop[i] = 0;
            m_fd[i]   = '0;
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        acc = v;
        if (m_hold[i]) begin
            if (rdy) begin
                m_hold[i] = 1'b0;
                m_hunt[i] = (i == 1);
            end else begin
                acc = 1'b0;
                if (v && m_drop[i] < drop_max(i)) m_drop[i]++;
            end
        end
        if (acc) begin
            if (m_hunt[i]) begin
                if (d == 8'hA5) m_hunt[i] = 1'b0;
            end else begin
                m_fd[i][m_cnt[i]*8 +: 8] = d;
                m_cnt[i]++;
                m_idle[i] = 0;
                if (m_cnt[i] == 16) begin
                    m_cnt[i]  = 0;
                    m_hold[i] = 1'b1;
                    if (i == 0) exp_q0.push_back(m_fd[i]); else exp_q1.push_back(m_fd[i]);
                end
            end
        end else if (!m_hold[i] && m_cnt[i] > 0) begin
            m_idle[i]++;
            if (m_idle[i] == TMO) begin
                m_cnt[i]  = 0;
                m_idle[i] = 0;
                m_hunt[i] = (i == 1);
                m_to[i]   = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic r0, input logic r1, input logic rs);
        @(posedge clk);
        #1;
        byte_valid = v;
        byte_data  = d;
        rdy0       = r0;
        rdy1       = r1;
        rst        = rs;
        model_cycle(0, v, d, r0, rs);
        model_cycle(1, v, d, r1, rs);
    endtask

    task automatic mon_inst(input int i, input logic fv, input logic [127:0] fd, input logic [4:0] bi,
                            input logic to, input logic [15:0] dc, input logic rdy);
        logic [127:0] e;
        int n;
        chk("frame_valid", i, 128'(fv), 128'(s_hold[i]));
        chk("byte_index", i, 128'(bi), 128'(s_cnt[i]));
        chk("timeout_err", i, 128'(to), 128'(s_to[i]));
        chk("drop_count", i, 128'(dc), 128'(s_drop[i]));
        chk("frame_data", i, fd, s_fd[i]);
        if (fv && rdy && !rst) begin
            n = (i == 0) ? exp_q0.size() : exp_q1.size();
            if (n == 0) begin
                total++;
                bad++;
                $display("FAIL handshake_frame inst%0d: got %h want no frame pending", i, fd);
            end else begin
                if (i == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
                chk("handshake_frame", i, fd, e);
            end
        end
    endtask

    // monitor: compare DUT against the model mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_inst(0, fv0, fd0, bi0, to0, dc0, rdy0);
                mon_inst(1, fv1, fd1, bi1, to1, {14'd0, dc1}, rdy1);
            end
        end
    end

    initial begin
        int pulses;
        logic v, r0, r1, rs;
        logic [7:0] d;
        for (int i = 0; i < 2; i++) begin
            m_hunt[i] = (i == 1); m_hold[i] = 1'b0; m_to[i] = 1'b0;
            m_cnt[i] = 0; m_idle[i] = 0; m_drop[i] = 0; m_fd[i] = '0;
            s_hold[i] = 1'b0; s_to[i] = 1'b0; s_cnt[i] = 0; s_drop[i] = 0; s_fd[i] = '0;
        end

        repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_frame_data", 0, fd0, 128'd0);
        chk("reset_drop_count", 1, 128'(dc1), 128'd0);

        // back-to-back 00..0F with ready held high
        for (int k = 0; k < 16; k++) tick(1'b1, 8'(k), 1'b1, 1'b1, 1'b0);
        tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_valid", 0, 128'(fv0), 128'd1);
        chk("t1_frame", 0, fd0, 128'h0F0E0D0C0B0A09080706050403020100);
        tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_valid_pulse", 0, 128'(fv0), 128'd0);

        // sync header: 33 ignored, A5 not stored
        tick(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) tick(1'b1, 8'(8'h40 + k), 1'b1, 1'b1, 1'b0);
        tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_valid", 1, 128'(fv1), 128'd1);
        chk("t2_frame", 1, fd1, 128'h4F4E4D4C4B4A49484746454443424140);
        chk("t2_drop", 1, 128'(dc1), 128'd0);
        repeat (12) tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);

        // five bytes then an idle stretch -> exactly one timeout
        for (int k = 0; k < 5; k++) tick(1'b1, 8'(8'h20 + k), 1'b1, 1'b1, 1'b0);
        pulses = 0;
        repeat (12) begin
            tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            if (to0) pulses++;
        end
        chk("t3_timeout_pulses", 0, 128'(pulses), 128'd1);
        chk("t3_index", 0, 128'(bi0), 128'd0);
        for (int k = 0; k < 16; k++) tick(1'b1, 8'(8'h50 + k), 1'b1, 1'b1, 1'b0);
        repeat (2) tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);

        // hold with ready low: three bytes dropped, frame frozen
        for (int k = 0; k < 16; k++) tick(1'b1, 8'(8'h60 + k), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b1, 8'(8'h70 + k), 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_drop", 0, 128'(dc0), 128'd3);
        chk("t4_frozen", 0, fd0, 128'h6F6E6D6C6B6A69686766656463626160);
        tick(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_release", 0, 128'(fv0), 128'd0);

        // ready and a byte in the same cycle: byte starts the next frame
        for (int k = 0; k < 16; k++) tick(1'b1, 8'(8'h80 + k), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_index", 0, 128'(bi0), 128'd1);
        chk("t5_byte0", 0, 128'(fd0[7:0]), 128'h7E);
        chk("t5_drop", 0, 128'(dc0), 128'd3);
        for (int k = 1; k < 16; k++) tick(1'b1, 8'(8'h80 + k), 1'b1, 1'b1, 1'b0);
        repeat (2) tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);

        // reset mid-collect and mid-hold
        for (int k = 0; k < 9; k++) tick(1'b1, 8'(8'h90 + k), 1'b1, 1'b1, 1'b0);
        tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b1);
        tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_index", 0, 128'(bi0), 128'd0);
        chk("t6_frame", 0, fd0, 128'd0);
        chk("t6_drop", 0, 128'(dc0), 128'd0);
        for (int k = 0; k < 16; k++) tick(1'b1, 8'(8'h90 + k), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b1);
        tick(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_hold_cleared", 0, 128'(fv0), 128'd0);
        chk("t6_hold_drop", 0, 128'(dc0), 128'd0);
        for (int k = 0; k < 16; k++) tick(1'b1, 8'(8'hB0 + k), 1'b1, 1'b1, 1'b0);
        tick(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_fresh_frame", 0, fd0, 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0);

        // randomized traffic with idle gaps around the timeout boundary
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(7, 12))
                    tick(1'b0, 8'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, 1'b0);
            end
            v  = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            r0 = ($urandom_range(0, 9) < 3);
            r1 = ($urandom_range(0, 9) < 3);
            rs = ($urandom_range(0, 499) == 0);
            tick(v, d, r0, r1, rs);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
